magma_core: RTL and testbench
=============================

# magma_core

GOST R 34.12-2015 "Magma" block-cipher engine that encrypts or decrypts a 128-bit word as two independent 64-bit blocks (ECB). It sits directly downstream of the data/key entry driver. It takes the entered data, the 256-bit key, the mode bit and a one-cycle start pulse, and returns the 128-bit result plus a done flag to the display path. It is iterative, with UNROLL Feistel rounds per clock.

## Interface
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 4, 8.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE or DONE.
- data_in  in  128  operand; [127:64] is block H, [63:0] is block L.
- key  in  256  cipher key; K1=key[255:224] … K8=key[31:0].
- encr_decr  in  1  1 = encrypt, 0 = decrypt.
- data_out  out  128  result; [127:64] from H, [63:0] from L.
- done  out  1  result valid, held as a level.

## Operation
- States:
  - IDLE: after reset.
  - RUN_H
  - RUN_L
  - DONE
- Transitions:
  - IDLE or DONE with start=1 goes to RUN_H. On that edge, capture data_in, key and encr_decr into internal registers, clear the round counter, and drop done to 0.
  - RUN_H goes to RUN_L after 32 rounds. Block H's result goes to an internal holding register. Block L is loaded into the Feistel register.
  - RUN_L goes to DONE after 32 rounds. data_out is written with {H result, L result} in a single edge, and done goes to 1.
- start in RUN_H or RUN_L is ignored. The captured operands do not change. Input changes after capture have no effect.
- Round function:
  - Split the block as a1=blk[63:32], a0=blk[31:0].
  - g(k,a) = ROTL11(S((a + k) mod 2^32)).
  - Rounds 1–31: (a1,a0) ← (a0, g(k,a0) ^ a1).
  - Round 32, no swap: result = {g(k,a0) ^ a1, a0}.
- S is the RFC 8891 π set. π0 applies to bits [3:0], up through π7 on bits [31:28].
- Round keys:
  - Encrypt: K1..K8, K1..K8, K1..K8, K8..K1.
  - Decrypt: K1..K8, K8..K1, K8..K1, K8..K1.
  - Select the key by round index (5-bit counter, wraps 31→0 between blocks).
- With UNROLL>1, combinationally chain UNROLL rounds per edge. Only the last round of the block omits the swap.
- All additions are 32-bit and discard the carry.

## Timing
- Reset values: data_out=128'h0, done=0, state IDLE, counter 0, internal registers 0.
- Reset has priority over start. Reset mid-run aborts: next cycle IDLE, done=0, data_out=0.
- Let the capture edge be E0. Block H completes at E0+32/UNROLL. done=1 and data_out are valid at E0+64/UNROLL.
  - UNROLL=1: 64 cycles.
  - UNROLL=8: 8 cycles.
- data_out holds its previous value throughout RUN_H and RUN_L. It changes only on the completing edge or on reset.
- done stays high in DONE until the edge that accepts the next start.
- A start on the same edge that enters DONE is ignored. This is because it arrives in RUN_L.
- Back-to-back: a start one cycle after done rises is accepted.

## Configuration
- MAGMA_DECRYPT_EN defined: encr_decr selects the key order as above.
- MAGMA_DECRYPT_EN undefined:
  - Decrypt key-order logic is not built.
  - encr_decr is ignored, and the core always encrypts.
  - The captured mode register is absent.

## Test plan
- Encrypt RFC vector:
  - Stimulus: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data_in=fedcba9876543210_fedcba9876543210, encr_decr=1, start pulse.
  - Response: data_out=4ee901e5c2d8ca3d_4ee901e5c2d8ca3d and done=1 exactly 64/UNROLL edges after capture.
- Decrypt (macro defined):
  - Stimulus: same key, data_in=4ee901e5c2d8ca3d_0123456789abcdef's ciphertext pair, encr_decr=0.
  - Response: recovered plaintexts, with H and L independent.
- Round trip, 100 random key/data pairs:
  - Encrypt then decrypt.
  - Response: original data_in; done low during each run.
- start pulses during RUN_H and RUN_L with changed data_in:
  - Response: result matches the first operand; latency unchanged.
- reset asserted at round 40 of 64:
  - Response: next cycle done=0, data_out=0. A fresh start then completes normally with the correct vector.
- Macro undefined:
  - Stimulus: encr_decr=0 with the RFC plaintext.
  - Response: data_out=4ee901e5c2d8ca3d_4ee901e5c2d8ca3d (encrypt).

Source files
------------

// File: rtl/magma_core.sv
// magma_core: iterative GOST R 34.12-2015 "Magma" ECB engine; a 128-bit word is two 64-bit blocks, H then L.
// Optional: define MAGMA_DECRYPT_EN to build the decrypt key order (otherwise the core always encrypts).

module magma_round (
   input  logic [31:0] rk,
   input  logic        last,
   input  logic [63:0] blk_i,
   output logic [63:0] blk_o
);
   // pi_n packed with the entry for input 0 in the low nibble
   localparam logic [7:0][63:0] PI = {
      64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8, 64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
      64'hB9E35A076F4D128C, 64'h069C471EDAF2853B, 64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C};

   logic [31:0] sum, sub, g;

   always_comb begin
      sum = blk_i[31:0] + rk;
      sub = '0;
      for (int n = 0; n < 8; n++)
         sub[4*n +: 4] = PI[n][{sum[4*n +: 4], 2'b00} +: 4];
      g = {sub[20:0], sub[31:21]} ^ blk_i[63:32];
      blk_o = last ? {g, blk_i[31:0]} : {blk_i[31:0], g};
   end
endmodule

module magma_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] data_in,
   input  logic [255:0] key,
   input  logic         encr_decr,
   output logic [127:0] data_out,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, RUN_H, RUN_L, DONE} state_t;

   state_t               state, state_d;
   logic [63:0]          blk, blk_l, hold_h;
   logic [255:0]         key_q;
   logic [4:0]           rnd;
   logic                 cap, blk_end;
   logic [UNROLL:0][63:0] chain;
`ifdef MAGMA_DECRYPT_EN
   logic                 mode_q;
`else
   logic                 unused_mode;
   assign unused_mode = encr_decr;
`endif

   assign blk_end  = (rnd == 5'(32 - UNROLL));
   assign chain[0] = blk;

   for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
      logic [4:0]  r;
      logic [2:0]  kidx;
      logic        rev;
      logic [31:0] rk;
      assign r = rnd + 5'(j);
`ifdef MAGMA_DECRYPT_EN
      // decrypt walks K1..K8 forward only in the first eight rounds
      assign rev = mode_q ? (r[4:3] == 2'b11) : (r[4:3] != 2'b00);
`else
      assign rev = (r[4:3] == 2'b11);
`endif
      assign kidx = rev ? ~r[2:0] : r[2:0];
      assign rk   = key_q[{~kidx, 5'd0} +: 32];
      magma_round u_round (
         .rk    (rk),
         .last  (r == 5'd31),
         .blk_i (chain[j]),
         .blk_o (chain[j+1])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      cap     = 1'b0;
      case (state)
         IDLE, DONE: if (start) begin
            state_d = RUN_H;
            cap     = 1'b1;
         end
         RUN_H:   if (blk_end) state_d = RUN_L;
         RUN_L:   if (blk_end) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blk      <= '0;
         blk_l    <= '0;
         hold_h   <= '0;
         key_q    <= '0;
         rnd      <= '0;
         data_out <= '0;
         done     <= 1'b0;
`ifdef MAGMA_DECRYPT_EN
         mode_q   <= 1'b0;
`endif
      end else if (cap) begin
         blk   <= data_in[127:64];
         blk_l <= data_in[63:0];
         key_q <= key;
         rnd   <= '0;
         done  <= 1'b0;
`ifdef MAGMA_DECRYPT_EN
         mode_q <= encr_decr;
`endif
      end else if (state == RUN_H || state == RUN_L) begin
         rnd <= rnd + 5'(UNROLL);
         blk <= chain[UNROLL];
         if (blk_end && state == RUN_H) begin
            hold_h <= chain[UNROLL];
            blk    <= blk_l;
         end
         if (blk_end && state == RUN_L) begin
            data_out <= {hold_h, chain[UNROLL]};
            done     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_magma_core.sv
// Scoreboard bench for magma_core: driver pushes expected words, a negedge monitor pops on each done rise.
module tb_magma_core;
   localparam int UNROLL = 4;
   localparam int LAT    = 64 / UNROLL;
   localparam logic [63:0]  P       = 64'hfedcba9876543210;
   localparam logic [63:0]  C       = 64'h4ee901e5c2d8ca3d;
   localparam logic [255:0] RFC_KEY =
      256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

   logic         clk = 1'b0;
   logic         reset, start, encr_decr, done;
   logic [127:0] data_in, data_out;
   logic [255:0] key;

   magma_core #(.UNROLL(UNROLL)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key(key),
      .encr_decr(encr_decr), .data_out(data_out), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           n_pass = 0, n_tot = 0;
   logic [127:0] exp_q[$];
   int           cap_q[$];
   logic         done_q = 1'b0;

   int PI_T [8][16] = '{
      '{12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1},
      '{6,8,2,3,9,10,5,12,1,14,4,7,11,13,0,15},
      '{11,3,5,8,2,15,10,13,14,1,7,4,12,9,6,0},
      '{12,8,2,1,13,4,15,6,7,0,10,5,3,14,9,11},
      '{7,15,5,10,8,1,6,13,0,9,3,14,11,4,2,12},
      '{5,13,15,6,9,2,12,10,11,7,8,1,4,3,14,0},
      '{8,14,2,5,6,9,1,12,15,4,11,0,13,10,3,7},
      '{1,7,14,13,0,5,8,3,4,15,10,6,9,12,11,2}};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // reference: straight transcription of the cipher rules, one round per loop step
   function automatic logic [63:0] ref_blk(input logic [255:0] k, input logic [63:0] b, input bit enc);
      logic [31:0] a1, a0, t, s, g;
      int ki;
      a1 = b[63:32];
      a0 = b[31:0];
      for (int i = 0; i < 32; i++) begin
         if (enc) ki = (i < 24) ? i % 8 : 7 - i % 8;
         else     ki = (i < 8)  ? i     : 7 - i % 8;
         t = a0 + k[255 - 32*ki -: 32];
         for (int n = 0; n < 8; n++) s[4*n +: 4] = 4'(PI_T[n][t[4*n +: 4]]);
         g = ((s << 11) | (s >> 21)) ^ a1;
         if (i == 31) return {g, a0};
         a1 = a0;
         a0 = g;
      end
      return '0;
   endfunction

   function automatic logic [127:0] ref_word(input logic [255:0] k, input logic [127:0] d, input bit enc);
      return {ref_blk(k, d[127:64], enc), ref_blk(k, d[63:0], enc)};
   endfunction

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] r256();
      return {r128(), r128()};
   endfunction

   always @(negedge clk) begin
      if (done && !done_q) begin
         check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            check("data_out", data_out, exp_q.pop_front());
            check("latency", 128'(cyc - cap_q.pop_front()), 128'(LAT));
         end
      end
      done_q = done;
   end

   task automatic run_op(input logic [127:0] d, input logic [255:0] k, input logic m,
                         input logic [127:0] exp, input bit poke);
      bit seen;
      seen = 1'b0;
      data_in = d; key = k; encr_decr = m; start = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(exp);
      cap_q.push_back(cyc);
      start = 1'b0; data_in = r128(); key = ~k; encr_decr = ~m;
      for (int c = 1; c <= LAT + 4 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) check("done_low_in_run", done, 0);
         if (done) seen = 1'b1;
         else start = poke && (c == 2 || c == LAT/2 + 1 || c == LAT - 1);
         data_in = r128();
      end
      start = 1'b0;
      check("completed", seen, 1);
      if (poke) begin
         @(negedge clk);
         check("done_held", done, 1);
      end
   endtask

   initial begin
      logic [127:0] d, ct;
      logic [255:0] k;
      logic [63:0]  lo;
      reset = 1'b1; start = 1'b0; data_in = '0; key = '0; encr_decr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data_out", data_out, 0);
      check("reset_done", done, 0);
      reset = 1'b0;

      run_op({P, P}, RFC_KEY, 1'b1, {C, C}, 1'b0);
`ifdef MAGMA_DECRYPT_EN
      lo = r128()[63:0];
      run_op({C, ref_blk(RFC_KEY, lo, 1'b1)}, RFC_KEY, 1'b0, {P, lo}, 1'b0);
`else
      lo = '0;
      run_op({P, P}, RFC_KEY, 1'b0, {C, C}, 1'b0);
`endif

      d = r128(); k = r256();
      run_op(d, k, 1'b1, ref_word(k, d, 1'b1), 1'b1);

      // abort at round 40 of 64
      data_in = r128(); key = r256(); encr_decr = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40 / UNROLL) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_done", done, 0);
      check("abort_data_out", data_out, 0);
      reset = 1'b0;
      run_op({P, P}, RFC_KEY, 1'b1, {C, C}, 1'b0);

      for (int i = 0; i < 100; i++) begin
         d = r128(); k = r256();
         ct = ref_word(k, d, 1'b1);
         run_op(d, k, 1'b1, ct, (i % 10) == 0);
`ifdef MAGMA_DECRYPT_EN
         run_op(ct, k, 1'b0, d, 1'b0);
`else
         run_op(ct, k, 1'b0, ref_word(k, ct, 1'b1), 1'b0);
`endif
      end

      repeat (2) @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
